// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
package prefetch_pkg;

  localparam int A_WIDTH = 8;
  localparam int I_WIDTH = 12;
  localparam int DEPTH   = 4;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  // One buffered fetch result: the address it was read from and the word.
  typedef struct packed {
    logic [A_WIDTH-1:0] addr;
    logic [I_WIDTH-1:0] data;
  } fetch_entry_s;

  typedef logic [CNT_W-1:0] fifo_cnt_t;
  typedef logic [PTR_W-1:0] fifo_ptr_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and a registered head view.
// The head register holds its last value while the FIFO is empty.
module fetch_fifo
  import prefetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_s push_entry_i,
  input  logic         pop_i,
  output fetch_entry_s head_o,
  output fifo_cnt_t    count_o,
  output logic         empty_o,
  output logic         full_o
);

  fetch_entry_s mem_q [DEPTH];
  fetch_entry_s mem_d [DEPTH];
  fifo_ptr_t    wr_ptr_q, wr_ptr_d;
  fifo_ptr_t    rd_ptr_q, rd_ptr_d;
  fifo_cnt_t    count_q, count_d;
  fetch_entry_s head_q, head_d;

  logic         push_ok_s;
  logic         pop_ok_s;
  fifo_ptr_t    rd_next_s;

  assign empty_o = (count_q == fifo_cnt_t'(0));
  assign full_o  = (count_q == fifo_cnt_t'(DEPTH));
  assign count_o = count_q;
  assign head_o  = head_q;

  // Next-state for storage, pointers, count and the head view; flush wins.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    head_d    = head_q;
    rd_next_s = rd_ptr_q + fifo_ptr_t'(1);
    pop_ok_s  = pop_i && !empty_o && !flush_i;
    push_ok_s = push_i && !flush_i && (!full_o || pop_ok_s);

    if (flush_i) begin
      wr_ptr_d = fifo_ptr_t'(0);
      rd_ptr_d = fifo_ptr_t'(0);
      count_d  = fifo_cnt_t'(0);
    end else begin
      if (push_ok_s) begin
        mem_d[wr_ptr_q] = push_entry_i;
        wr_ptr_d        = wr_ptr_q + fifo_ptr_t'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_next_s;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + fifo_cnt_t'(push_ok_s) - fifo_cnt_t'(pop_ok_s);

      // Head tracks the entry that will sit at the read pointer next cycle.
      if (count_d == fifo_cnt_t'(0)) begin
        head_d = head_q;
      end else if (pop_ok_s) begin
        head_d = (count_q > fifo_cnt_t'(1)) ? mem_q[rd_next_s] : push_entry_i;
      end else if (empty_o) begin
        head_d = push_entry_i;
      end else begin
        head_d = mem_q[rd_ptr_q];
      end
    end
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= fifo_ptr_t'(0);
      rd_ptr_q <= fifo_ptr_t'(0);
      count_q  <= fifo_cnt_t'(0);
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/prefetch_checker.sv
// Protocol checker for the prefetch FIFO: flags any push that would overflow.
module prefetch_checker (
  input logic clk,
  input logic rst_n,
  input logic push_i,
  input logic pop_i,
  input logic full_i,
  input logic flush_i
);

  // Credit accounting must never let a push land on a full FIFO without a pop.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(push_i && full_i && !pop_i && !flush_i))
    else $error("prefetch fifo overflow");

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch stage: PC, memory read issue with credit control,
// in-flight tracking, restart handling and a small prefetch FIFO.
module instr_prefetch
  import prefetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n_i,
  input  logic               deque_i,
  input  logic               restart_i,
  input  logic [A_WIDTH-1:0] restart_addr_i,
  output logic [I_WIDTH-1:0] instruction_data_o,
  output logic [A_WIDTH-1:0] instruction_addr_o,
  output logic               instruction_ready_o,
  output logic               imem_req_o,
  output logic [A_WIDTH-1:0] imem_addr_o,
  input  logic [I_WIDTH-1:0] imem_data_i
);

  logic [A_WIDTH-1:0] pc_q, pc_d;
  // Valid bit of the read in flight; clearing it on restart drops the return.
  logic               inflight_q, inflight_d;
  logic [A_WIDTH-1:0] inflight_addr_q, inflight_addr_d;

  fifo_cnt_t    count_s;
  fifo_cnt_t    credit_used_s;
  logic         empty_s;
  logic         full_s;
  logic         issue_s;
  logic         push_s;
  logic         pop_s;
  fetch_entry_s push_entry_s;
  fetch_entry_s head_s;

  // Credit ignores same-cycle dequeues, so it is conservative by one slot.
  assign credit_used_s = count_s + fifo_cnt_t'(inflight_q);
  assign issue_s       = reset_n_i && !restart_i && (credit_used_s < fifo_cnt_t'(DEPTH));
  assign push_s        = inflight_q;
  assign pop_s         = deque_i && !empty_s;
  assign push_entry_s  = '{addr: inflight_addr_q, data: imem_data_i};

  assign imem_req_o          = issue_s;
  assign imem_addr_o         = pc_q;
  assign instruction_ready_o = !empty_s;
  assign instruction_addr_o  = head_s.addr;
  assign instruction_data_o  = head_s.data;

  // PC and in-flight tracking; restart redirects and kills any pending return.
  always_comb begin
    pc_d            = pc_q;
    inflight_d      = issue_s;
    inflight_addr_d = inflight_addr_q;
    if (restart_i) begin
      pc_d = restart_addr_i;
    end else if (issue_s) begin
      pc_d            = pc_q + {{(A_WIDTH-1){1'b0}}, 1'b1};
      inflight_addr_d = pc_q;
    end else begin
      pc_d = pc_q;
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pc_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      pc_q            <= pc_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
    end
  end

  fetch_fifo u_fifo (
    .clk          (clk),
    .rst_n        (reset_n_i),
    .flush_i      (restart_i),
    .push_i       (push_s),
    .push_entry_i (push_entry_s),
    .pop_i        (pop_s),
    .head_o       (head_s),
    .count_o      (count_s),
    .empty_o      (empty_s),
    .full_o       (full_s)
  );

  prefetch_checker u_chk (
    .clk     (clk),
    .rst_n   (reset_n_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .full_i  (full_s),
    .flush_i (restart_i)
  );

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch; memory model returns {4'hA, addr}.
module tb_instr_prefetch;

  logic        clk;
  logic        reset_n;
  logic        deque;
  logic        restart;
  logic [7:0]  restart_addr;
  logic [11:0] instr_data;
  logic [7:0]  instr_addr;
  logic        instr_ready;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [11:0] imem_data;

  int total = 0;
  int bad   = 0;

  instr_prefetch dut (
    .clk                 (clk),
    .reset_n_i           (reset_n),
    .deque_i             (deque),
    .restart_i           (restart),
    .restart_addr_i      (restart_addr),
    .instruction_data_o  (instr_data),
    .instruction_addr_o  (instr_addr),
    .instruction_ready_o (instr_ready),
    .imem_req_o          (imem_req),
    .imem_addr_o         (imem_addr),
    .imem_data_i         (imem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after the address.
  always @(posedge clk) imem_data <= {4'hA, imem_addr};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; deque = 1'b0; restart = 1'b0; restart_addr = 8'h00;
    tick(); tick();
    // Reset state
    chk("rst_ready", 32'(instr_ready), 32'h0);
    chk("rst_data",  32'(instr_data),  32'h0);
    chk("rst_addr",  32'(instr_addr),  32'h0);
    chk("rst_req",   32'(imem_req),    32'h0);
    chk("rst_imaddr", 32'(imem_addr),  32'h0);

    // Fill after reset release with no dequeue (cycle c0)
    reset_n = 1'b1; #1;
    chk("c0_req", 32'(imem_req), 32'h1);
    chk("c0_imaddr", 32'(imem_addr), 32'h00);
    tick(); // c1
    chk("c1_imaddr", 32'(imem_addr), 32'h01);
    chk("c1_ready", 32'(instr_ready), 32'h0);
    tick(); // c2
    chk("c2_ready", 32'(instr_ready), 32'h1);
    chk("c2_addr", 32'(instr_addr), 32'h00);
    chk("c2_data", 32'(instr_data), 32'hA00);
    chk("c2_imaddr", 32'(imem_addr), 32'h02);
    tick(); // c3
    chk("c3_req", 32'(imem_req), 32'h1);
    chk("c3_imaddr", 32'(imem_addr), 32'h03);
    tick(); // c4
    chk("c4_req", 32'(imem_req), 32'h0);
    tick(); // c5: full
    chk("c5_req", 32'(imem_req), 32'h0);
    chk("c5_ready", 32'(instr_ready), 32'h1);
    chk("c5_data", 32'(instr_data), 32'hA00);
    deque = 1'b1;
    tick(); // c6: one popped, refill issue of 4
    deque = 1'b0;
    chk("c6_addr", 32'(instr_addr), 32'h01);
    chk("c6_data", 32'(instr_data), 32'hA01);
    #1;
    chk("c6_req", 32'(imem_req), 32'h1);
    chk("c6_imaddr", 32'(imem_addr), 32'h04);
    tick(); // c7: full-by-credit with 0x04 in flight -> restart
    restart = 1'b1; restart_addr = 8'h40; #1;
    chk("rs_req", 32'(imem_req), 32'h0);
    tick(); // t+1
    restart = 1'b0;
    chk("rs_t1_ready", 32'(instr_ready), 32'h0);
    chk("rs_t1_hold", 32'(instr_addr), 32'h01);
    #1;
    chk("rs_t1_imaddr", 32'(imem_addr), 32'h40);
    chk("rs_t1_req", 32'(imem_req), 32'h1);
    tick(); // t+2
    chk("rs_t2_ready", 32'(instr_ready), 32'h0);
    tick(); // t+3
    chk("rs_t3_ready", 32'(instr_ready), 32'h1);
    chk("rs_t3_addr", 32'(instr_addr), 32'h40);
    chk("rs_t3_data", 32'(instr_data), 32'hA40);
    deque = 1'b1;
    tick();
    chk("rs_s1_addr", 32'(instr_addr), 32'h41);
    tick();
    chk("rs_s2_addr", 32'(instr_addr), 32'h42);
    chk("rs_s2_data", 32'(instr_data), 32'hA42);

    // Restart together with dequeue
    restart = 1'b1; restart_addr = 8'h80;
    tick();
    restart = 1'b0; deque = 1'b0;
    chk("rd_t1_ready", 32'(instr_ready), 32'h0);
    tick();
    chk("rd_t2_ready", 32'(instr_ready), 32'h0);
    tick();
    chk("rd_t3_ready", 32'(instr_ready), 32'h1);
    chk("rd_t3_addr", 32'(instr_addr), 32'h80);

    // Wrap-around from 0xFE with continuous dequeue
    restart = 1'b1; restart_addr = 8'hFE;
    tick();
    restart = 1'b0; deque = 1'b1;
    tick();
    chk("wr_t2_ready", 32'(instr_ready), 32'h0);
    tick();
    chk("wr_fe", 32'(instr_addr), 32'hFE);
    chk("wr_fe_ready", 32'(instr_ready), 32'h1);
    tick();
    chk("wr_ff", 32'(instr_addr), 32'hFF);
    tick();
    chk("wr_00", 32'(instr_addr), 32'h00);
    chk("wr_00_data", 32'(instr_data), 32'hA00);
    tick();
    chk("wr_01", 32'(instr_addr), 32'h01);
    chk("wr_01_ready", 32'(instr_ready), 32'h1);

    // Asynchronous reset mid-cycle while streaming
    #2 reset_n = 1'b0;
    #1;
    chk("ar_ready", 32'(instr_ready), 32'h0);
    chk("ar_data", 32'(instr_data), 32'h0);
    chk("ar_addr", 32'(instr_addr), 32'h0);
    chk("ar_req", 32'(imem_req), 32'h0);
    chk("ar_imaddr", 32'(imem_addr), 32'h0);
    @(negedge clk);
    reset_n = 1'b1; #1;
    chk("ar_c0_req", 32'(imem_req), 32'h1);
    chk("ar_c0_imaddr", 32'(imem_addr), 32'h00);
    tick();
    chk("ar_c1_ready", 32'(instr_ready), 32'h0);
    tick();
    chk("ar_c2_ready", 32'(instr_ready), 32'h1);
    chk("ar_c2_addr", 32'(instr_addr), 32'h00);
    chk("ar_c2_data", 32'(instr_data), 32'hA00);
    tick();
    chk("ar_c3_addr", 32'(instr_addr), 32'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
